yj_cdc_handshake_tx: RTL

YJ_CDC_HANDSHAKE_TX -- requirements
Module: yj_cdc_handshake_tx

---
 rtl/yj_cdc_handshake_tx_pkg.sv | 20 ++
 rtl/yj_cdc_handshake_tx_if.sv | 28 ++
 rtl/yj_basic_signal_2lever_sync.sv | 24 ++
 rtl/yj_cdc_handshake_tx.sv | 93 +++++++++
 4 files changed

// File: rtl/yj_cdc_handshake_tx_pkg.sv
// Shared constants and types for the source side of the 4-phase CDC handshake.
// The state encoding is fixed so debug taps and checkers can decode it directly.
package yj_cdc_handshake_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } hs_state_t;

    localparam int DEFAULT_DW  = 32;
    localparam int ACK_SYNC_DW = 1;

    // A new word may only be taken once the previous handshake has fully
    // returned to zero on both sides.
    function automatic logic can_accept(hs_state_t s, logic ack_s);
        return (s == IDLE) && !ack_s;
    endfunction

endpackage

// File: rtl/yj_cdc_handshake_tx_if.sv
// Bus bundle for the CDC handshake transmitter: source-side valid/ready plus
// the req/ack/data wires that cross into the destination domain.
interface yj_cdc_handshake_tx_if #(
    parameter int DW = 32
);
    // Source side: a word transfers on a rising CLK edge where tx_valid and
    // tx_ready are both high; tx_valid/tx_data must stay put until then.
    // Crossing side: cdc_req up -> cdc_ack up -> cdc_req down -> cdc_ack down,
    // with cdc_data stable whenever cdc_req is high.
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_ready;
    logic          tx_done;
    logic          cdc_req;
    logic [DW-1:0] cdc_data;
    logic          cdc_ack;

    modport master (
        input  tx_valid, tx_data, cdc_ack,
        output tx_ready, tx_done, cdc_req, cdc_data
    );

    modport slave (
        output tx_valid, tx_data, cdc_ack,
        input  tx_ready, tx_done, cdc_req, cdc_data
    );

endinterface

// File: rtl/yj_basic_signal_2lever_sync.sv
// Two-flop synchroniser for level signals entering the CLK domain.
// Each bit is synchronised independently; only use DW>1 for unrelated levels.
module yj_basic_signal_2lever_sync #(
    parameter int DW = 1
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] meta;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            meta <= '0;
            dout <= '0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/yj_cdc_handshake_tx.sv
// Source-domain half of a 4-phase return-to-zero CDC handshake: holds one word
// in flops, raises cdc_req, and waits for the synchronised ack to cycle.
module yj_cdc_handshake_tx
    import yj_cdc_handshake_tx_pkg::*;
#(
    parameter int   DW     = DEFAULT_DW,
    parameter logic RSTVAL = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    yj_cdc_handshake_tx_if.master bus,
    output hs_state_t             debug_state
);

    hs_state_t     state_q;
    hs_state_t     state_d;
    logic          req_q;
    logic          req_d;
    logic          done_q;
    logic          done_d;
    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;
    logic          ack_s;
    logic          ready;

    yj_basic_signal_2lever_sync #(
        .DW(ACK_SYNC_DW)
    ) u_ack_sync (
        .CLK (CLK),
        .RSTn(RSTn),
        .din (bus.cdc_ack),
        .dout(ack_s)
    );

    // Ready depends on registered state and the synchronised ack only, so no
    // combinational path exists from cdc_ack or tx_valid to any output.
    assign ready = can_accept(state_q, ack_s);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.tx_valid && ready) begin
                    data_d  = bus.tx_data;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                req_d = 1'b1;
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = REL;
                end
            end
            REL: begin
                req_d = 1'b0;
                if (!ack_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= {DW{RSTVAL}};
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            done_q  <= done_d;
            data_q  <= data_d;
        end
    end

    assign bus.tx_ready = ready;
    assign bus.tx_done  = done_q;
    assign bus.cdc_req  = req_q;
    assign bus.cdc_data = data_q;
    assign debug_state  = state_q;

endmodule
